// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI-Lite response codes and master state type shared by master and slave
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } axil_mst_state_t;

endpackage

// File: rtl/axilite_master_bridge.sv
// rtl/axilite_master_bridge.sv - single-outstanding command/response to AXI-Lite master with response timeout
module axilite_master_bridge
    import axil_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_write,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [DATA_W-1:0]   i_cmd_wdata,
    input  logic [DATA_W/8-1:0] i_cmd_wstrb,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic [1:0]          o_rsp_resp,
    output logic                o_rsp_timeout,
    output logic [ADDR_W-1:0]   o_m_axi_awaddr,
    output logic                o_m_axi_awvalid,
    input  logic                i_m_axi_awready,
    output logic [DATA_W-1:0]   o_m_axi_wdata,
    output logic [DATA_W/8-1:0] o_m_axi_wstrb,
    output logic                o_m_axi_wvalid,
    input  logic                i_m_axi_wready,
    input  logic                i_m_axi_bvalid,
    input  logic [1:0]          i_m_axi_bresp,
    output logic                o_m_axi_bready,
    output logic [ADDR_W-1:0]   o_m_axi_araddr,
    output logic                o_m_axi_arvalid,
    input  logic                i_m_axi_arready,
    input  logic                i_m_axi_rvalid,
    input  logic [DATA_W-1:0]   i_m_axi_rdata,
    input  logic [1:0]          i_m_axi_rresp,
    output logic                o_m_axi_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT > 0);

    axil_mst_state_t    r_state;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [1:0]         r_rsp_resp;
    logic               r_rsp_timeout;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [STRB_W-1:0]  r_wstrb;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic               r_arvalid;
    logic               r_rready;
    logic               r_aw_done;
    logic               r_w_done;
    logic               r_drain;
    logic [CNT_W-1:0]   r_cnt;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_wr_both;
    logic w_drain_hit;

    assign w_aw_hs     = r_awvalid && i_m_axi_awready;
    assign w_w_hs      = r_wvalid && i_m_axi_wready;
    assign w_wr_both   = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    // A late response after a timeout is swallowed here; nothing else can own bready/rready while draining.
    assign w_drain_hit = r_drain && ((r_bready && i_m_axi_bvalid) || (r_rready && i_m_axi_rvalid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_drain       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            if (w_drain_hit) begin
                r_drain  <= 1'b0;
                r_bready <= 1'b0;
                r_rready <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_cmd_ready && i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= i_cmd_addr;
                        r_wdata     <= i_cmd_wdata;
                        r_wstrb     <= i_cmd_wstrb;
                        if (i_cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_REQ;
                        end
                    end else begin
                        r_cmd_ready <= !r_drain || w_drain_hit;
                    end
                end
                ST_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_wr_both) begin
                        r_bready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (i_m_axi_bvalid) begin
                        r_rsp_resp    <= i_m_axi_bresp;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_bready      <= 1'b0;
                        r_state       <= ST_RSP;
                    end else if (TO_EN && r_cnt == CNT_LAST) begin
                        r_rsp_resp    <= RESP_SLVERR;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_drain       <= 1'b1;
                        r_state       <= ST_RSP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    if (i_m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (i_m_axi_rvalid) begin
                        r_rsp_resp    <= i_m_axi_rresp;
                        r_rsp_rdata   <= i_m_axi_rdata;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rready      <= 1'b0;
                        r_state       <= ST_RSP;
                    end else if (TO_EN && r_cnt == CNT_LAST) begin
                        r_rsp_resp    <= RESP_SLVERR;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_drain       <= 1'b1;
                        r_state       <= ST_RSP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RSP: begin
                    // Re-arming cmd_ready here lets a zero-wait slave sustain one transaction per 4 cycles.
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= !r_drain || w_drain_hit;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready     = r_cmd_ready;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_rdata     = r_rsp_rdata;
    assign o_rsp_resp      = r_rsp_resp;
    assign o_rsp_timeout   = r_rsp_timeout;
    assign o_m_axi_awaddr  = r_addr;
    assign o_m_axi_awvalid = r_awvalid;
    assign o_m_axi_wdata   = r_wdata;
    assign o_m_axi_wstrb   = r_wstrb;
    assign o_m_axi_wvalid  = r_wvalid;
    assign o_m_axi_bready  = r_bready;
    assign o_m_axi_araddr  = r_addr;
    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axilite_master_bridge.sv
// tb/tb_axilite_master_bridge.sv - directed self-checking bench for axilite_master_bridge
module tb_axilite_master_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int tests_run = 0;
    int tests_failed = 0;
    int aw_hs = 0;
    int w_hs = 0;

    always #5 clk = ~clk;

    axilite_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
        .o_m_axi_awaddr(awaddr), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
        .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wvalid(wvalid), .i_m_axi_wready(wready),
        .i_m_axi_bvalid(bvalid), .i_m_axi_bresp(bresp), .o_m_axi_bready(bready),
        .o_m_axi_araddr(araddr), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
        .i_m_axi_rvalid(rvalid), .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .o_m_axi_rready(rready)
    );

    always @(posedge clk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready)   w_hs  <= w_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_ready got %0b exp 0", cmd_ready); end
        tests_run++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin tests_failed++; $display("FAIL reset_valids got %b exp 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
        tests_run++; if ({awaddr, wdata, rsp_rdata, rsp_resp, rsp_timeout} !== 99'b0) begin tests_failed++; $display("FAIL reset_fields got %h %h %h %b %b exp 0", awaddr, wdata, rsp_rdata, rsp_resp, rsp_timeout); end
        rst_n = 1;
        tick();
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_cmd_ready got %0b exp 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        aw_hs = 0; w_hs = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        awready = 1; wready = 1;
        tick();
        cmd_valid = 0;
        tests_run++; if ({awvalid, wvalid, cmd_ready} !== 3'b110) begin tests_failed++; $display("FAIL wr_req_valids got %b exp 110", {awvalid, wvalid, cmd_ready}); end
        tests_run++; if (awaddr !== 32'h10 || wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin tests_failed++; $display("FAIL wr_req_fields got %h %h %h exp 10 deadbeef f", awaddr, wdata, wstrb); end
        tick();
        tests_run++; if ({awvalid, wvalid, bready} !== 3'b001) begin tests_failed++; $display("FAIL wr_after_hs got %b exp 001", {awvalid, wvalid, bready}); end
        tick(); tick();
        tests_run++; if ({rsp_valid, bready} !== 2'b01) begin tests_failed++; $display("FAIL wr_wait_b got %b exp 01", {rsp_valid, bready}); end
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0; awready = 0; wready = 0;
        tests_run++; if ({rsp_valid, bready, rsp_timeout} !== 3'b100 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL wr_rsp got v%b br%b to%b resp %b rdata %h exp 1 0 0 00 0", rsp_valid, bready, rsp_timeout, rsp_resp, rsp_rdata); end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        tests_run++; if ({rsp_valid, cmd_ready} !== 2'b01) begin tests_failed++; $display("FAIL wr_rsp_done got %b exp 01", {rsp_valid, cmd_ready}); end
        tests_run++; if (aw_hs !== 1 || w_hs !== 1) begin tests_failed++; $display("FAIL wr_hs_count got aw %0d w %0d exp 1 1", aw_hs, w_hs); end
    endtask

    task automatic test_write_staggered();
        aw_hs = 0; w_hs = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h44; cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3;
        tick();
        cmd_valid = 0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h0;
        tick();
        tests_run++; if ({awvalid, wvalid, bready} !== 3'b110) begin tests_failed++; $display("FAIL stag_hold got %b exp 110", {awvalid, wvalid, bready}); end
        awready = 1;
        tick();
        awready = 0;
        tests_run++; if ({awvalid, wvalid, bready} !== 3'b010) begin tests_failed++; $display("FAIL stag_aw_drop got %b exp 010", {awvalid, wvalid, bready}); end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++; if ({wvalid, bready} !== 2'b10 || awaddr !== 32'h44 || wdata !== 32'h12345678 || wstrb !== 4'h3) begin tests_failed++; $display("FAIL stag_stable[%0d] got wv%b br%b %h %h %h exp 1 0 44 12345678 3", i, wvalid, bready, awaddr, wdata, wstrb); end
        end
        wready = 1;
        tick();
        wready = 0;
        tests_run++; if ({awvalid, wvalid, bready} !== 3'b001) begin tests_failed++; $display("FAIL stag_both_done got %b exp 001", {awvalid, wvalid, bready}); end
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        tests_run++; if (aw_hs !== 1 || w_hs !== 1) begin tests_failed++; $display("FAIL stag_hs_count got aw %0d w %0d exp 1 1", aw_hs, w_hs); end
    endtask

    task automatic test_read();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
        tick();
        cmd_valid = 0;
        tests_run++; if (arvalid !== 1'b1 || araddr !== 32'h20 || awvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_req got arv%b %h awv%b exp 1 20 0", arvalid, araddr, awvalid); end
        arready = 1;
        tick();
        arready = 0;
        tests_run++; if ({arvalid, rready} !== 2'b01) begin tests_failed++; $display("FAIL rd_ar_hs got %b exp 01", {arvalid, rready}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if ({rready, rsp_valid} !== 2'b10) begin tests_failed++; $display("FAIL rd_wait[%0d] got %b exp 10", i, {rready, rsp_valid}); end
        end
        rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b10;
        tick();
        rvalid = 0; rdata = 0; rresp = 0;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || rsp_resp !== 2'b10 || rsp_timeout !== 1'b0 || rready !== 1'b0) begin tests_failed++; $display("FAIL rd_rsp got v%b %h %b to%b rr%b exp 1 cafef00d 10 0 0", rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, rready); end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_rsp_backpressure();
        arready = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
        tick();
        cmd_valid = 0;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h0BADF00D; rresp = 2'b01;
        tick();
        rvalid = 0; rdata = 0; rresp = 0;
        cmd_valid = 1; cmd_write = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D || rsp_resp !== 2'b01 || cmd_ready !== 1'b0 || awvalid !== 1'b0) begin tests_failed++; $display("FAIL bp_hold[%0d] got v%b %h %b cr%b awv%b exp 1 0badf00d 01 0 0", i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready, awvalid); end
        end
        cmd_valid = 0; cmd_write = 0;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        tests_run++; if ({rsp_valid, cmd_ready} !== 2'b01) begin tests_failed++; $display("FAIL bp_release got %b exp 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_timeout();
        awready = 1; wready = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h1;
        tick();
        cmd_valid = 0;
        tick();
        awready = 0; wready = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            tests_run++; if ({rsp_valid, bready} !== 2'b01) begin tests_failed++; $display("FAIL to_wait[%0d] got %b exp 01", i, {rsp_valid, bready}); end
        end
        tick();
        tests_run++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || bready !== 1'b1) begin tests_failed++; $display("FAIL to_rsp got v%b %b to%b %h br%b exp 1 10 1 0 1", rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, bready); end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        cmd_valid = 1; cmd_write = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if ({rsp_valid, cmd_ready, arvalid, bready} !== 4'b0001) begin tests_failed++; $display("FAIL to_drain[%0d] got %b exp 0001", i, {rsp_valid, cmd_ready, arvalid, bready}); end
        end
        cmd_valid = 0;
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        tests_run++; if ({bready, cmd_ready, rsp_valid} !== 3'b010) begin tests_failed++; $display("FAIL to_drained got %b exp 010", {bready, cmd_ready, rsp_valid}); end
    endtask

    task automatic test_timeout_race();
        awready = 1; wready = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h60;
        tick();
        cmd_valid = 0;
        tick();
        awready = 0; wready = 0;
        for (int i = 1; i < 8; i++) tick();
        bvalid = 1; bresp = 2'b01;
        tick();
        bvalid = 0; bresp = 0;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b01 || rsp_timeout !== 1'b0 || bready !== 1'b0) begin tests_failed++; $display("FAIL race_rsp got v%b %b to%b br%b exp 1 01 0 0", rsp_valid, rsp_resp, rsp_timeout, bready); end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL race_no_drain got cmd_ready %b exp 1", cmd_ready); end
    endtask

    task automatic test_back_to_back();
        int rsp_cnt;
        rsp_cnt = 0;
        arready = 1; rvalid = 1; rdata = 32'h55AA55AA; rresp = 2'b00; rsp_ready = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h70;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid) rsp_cnt++;
        end
        idle_inputs();
        tick();
        tests_run++; if (rsp_cnt !== 3) begin tests_failed++; $display("FAIL b2b_count got %0d exp 3", rsp_cnt); end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h80; cmd_wdata = 32'h2;
        tick();
        cmd_valid = 0;
        tests_run++; if (awvalid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre got awvalid %b exp 1", awvalid); end
        #2 rst_n = 0;
        #1;
        tests_run++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0) begin tests_failed++; $display("FAIL mid_abort got %b exp 0000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}); end
        tick();
        rst_n = 1;
        tick();
        tests_run++; if ({cmd_ready, rsp_valid, awvalid} !== 3'b100) begin tests_failed++; $display("FAIL mid_release got %b exp 100", {cmd_ready, rsp_valid, awvalid}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_spurious[%0d] got rsp_valid %b exp 0", i, rsp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_staggered();
        test_read();
        test_rsp_backpressure();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
